// File: rtl/nyakuo_pkg.sv
// Shared types and encodings for the nyakuo decode path.
// Opcode, funct3 and funct7 constants plus the decoded-class enum and output record.
package nyakuo_pkg;

    // Encoding 0 is ILLEGAL so a cleared output register reads as "no class".
    typedef enum logic [3:0] {
        ClsIllegal = 4'd0,
        ClsCalc    = 4'd1,
        ClsCalcImm = 4'd2,
        ClsLui     = 4'd3,
        ClsAuipc   = 4'd4,
        ClsJal     = 4'd5,
        ClsJalr    = 4'd6,
        ClsBranch  = 4'd7,
        ClsLoad    = 4'd8,
        ClsStore   = 4'd9
    } op_class_t;

    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;

    localparam logic [2:0] F3Add  = 3'b000;
    localparam logic [2:0] F3Sll  = 3'b001;
    localparam logic [2:0] F3Slt  = 3'b010;
    localparam logic [2:0] F3Sltu = 3'b011;
    localparam logic [2:0] F3Xor  = 3'b100;
    localparam logic [2:0] F3Sr   = 3'b101;
    localparam logic [2:0] F3Or   = 3'b110;
    localparam logic [2:0] F3And  = 3'b111;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;

    localparam logic [2:0] F3Sb = 3'b000;
    localparam logic [2:0] F3Sh = 3'b001;
    localparam logic [2:0] F3Sw = 3'b010;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    typedef struct packed {
        op_class_t   op_class;
        logic [2:0]  funct;
        logic        alt;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] imm;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        illegal;
    } dec_out_t;

endpackage

// File: rtl/decode_core.sv
// Combinational RV32I/RV32E decoder: class, funct, immediate, register fields and legality.
// Illegal encodings report no used registers so they never wait on the scoreboard.
module decode_core
    import nyakuo_pkg::*;
#(
    parameter int unsigned NREGS = 32
) (
    input  logic [31:0] inst_i,
    output op_class_t   op_class_o,
    output logic [2:0]  funct_o,
    output logic        alt_o,
    output logic [31:0] imm_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic        rs1_used_o,
    output logic        rs2_used_o,
    output logic        illegal_o
);

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i_fmt;
    logic [31:0] imm_s_fmt;
    logic [31:0] imm_b_fmt;
    logic [31:0] imm_u_fmt;
    logic [31:0] imm_j_fmt;

    op_class_t   cls;
    logic        use_rs1;
    logic        use_rs2;
    logic        use_rd;
    logic        alt;
    logic        legal;
    logic [31:0] imm;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];

    assign imm_i_fmt = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s_fmt = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b_fmt = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u_fmt = {inst_i[31:12], 12'b0};
    assign imm_j_fmt = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21],
                        1'b0};

    always_comb begin
        cls     = ClsIllegal;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        alt     = 1'b0;
        legal   = 1'b0;
        imm     = '0;
        case (opcode)
            OpcLui: begin
                cls    = ClsLui;
                use_rd = 1'b1;
                imm    = imm_u_fmt;
            end
            OpcAuipc: begin
                cls    = ClsAuipc;
                use_rd = 1'b1;
                imm    = imm_u_fmt;
            end
            OpcJal: begin
                cls    = ClsJal;
                use_rd = 1'b1;
                imm    = imm_j_fmt;
            end
            OpcJalr: begin
                imm = imm_i_fmt;
                if (funct3 == F3Add) begin
                    cls     = ClsJalr;
                    use_rs1 = 1'b1;
                    use_rd  = 1'b1;
                end
            end
            OpcBranch: begin
                imm = imm_b_fmt;
                if (funct3 != F3Slt && funct3 != F3Sltu) begin
                    cls     = ClsBranch;
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                end
            end
            OpcLoad: begin
                imm = imm_i_fmt;
                if (funct3 == F3Lb || funct3 == F3Lh || funct3 == F3Lw ||
                    funct3 == F3Lbu || funct3 == F3Lhu) begin
                    cls     = ClsLoad;
                    use_rs1 = 1'b1;
                    use_rd  = 1'b1;
                end
            end
            OpcStore: begin
                imm = imm_s_fmt;
                if (funct3 == F3Sb || funct3 == F3Sh || funct3 == F3Sw) begin
                    cls     = ClsStore;
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                end
            end
            OpcOpImm: begin
                imm = imm_i_fmt;
                // Shift-immediates reuse imm[11:5] as funct7 and must match exactly.
                case (funct3)
                    F3Sll:   legal = (funct7 == F7Base);
                    F3Sr:    legal = (funct7 == F7Base) || (funct7 == F7Alt);
                    default: legal = 1'b1;
                endcase
                if (legal) begin
                    cls     = ClsCalcImm;
                    use_rs1 = 1'b1;
                    use_rd  = 1'b1;
                    alt     = (funct3 == F3Sr) && inst_i[30];
                end
            end
            OpcOp: begin
                legal = (funct7 == F7Base) ||
                        ((funct7 == F7Alt) && (funct3 == F3Add || funct3 == F3Sr));
                if (legal) begin
                    cls     = ClsCalc;
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                    use_rd  = 1'b1;
                    alt     = inst_i[30];
                end
            end
            default: cls = ClsIllegal;
        endcase

        // RV32E has only x0..x15; any referenced register above that is illegal.
        if (NREGS == 16 && ((use_rs1 && inst_i[19]) || (use_rs2 && inst_i[24]) ||
                            (use_rd && inst_i[11]))) begin
            cls = ClsIllegal;
        end

        if (cls == ClsIllegal) begin
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
            use_rd  = 1'b0;
            alt     = 1'b0;
        end
    end

    assign op_class_o = cls;
    assign funct_o    = funct3;
    assign alt_o      = alt;
    assign imm_o      = imm;
    assign rs1_o      = inst_i[19:15];
    assign rs2_o      = inst_i[24:20];
    assign rd_o       = use_rd ? inst_i[11:7] : 5'd0;
    assign rs1_used_o = use_rs1;
    assign rs2_used_o = use_rs2;
    assign illegal_o  = (cls == ClsIllegal);

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decoded output register with valid/ready, operand selection and a
// load-destination scoreboard that holds fetch on load-use hazards.
module decode_stage
    import nyakuo_pkg::*;
#(
    parameter int unsigned NREGS         = 32,
    parameter int unsigned PC_W          = 32,
    parameter int unsigned EN_SCOREBOARD = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     in_inst_i,
    input  logic [PC_W-1:0] in_pc_i,
    output logic [4:0]      rf_raddr1_o,
    output logic [4:0]      rf_raddr2_o,
    input  logic [31:0]     rf_rdata1_i,
    input  logic [31:0]     rf_rdata2_i,
    input  logic            wb_valid_i,
    input  logic [4:0]      wb_rd_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [PC_W-1:0] out_pc_o,
    output op_class_t       out_class_o,
    output logic [2:0]      out_funct_o,
    output logic            out_alt_o,
    output logic [31:0]     out_op_a_o,
    output logic [31:0]     out_op_b_o,
    output logic [31:0]     out_imm_o,
    output logic [31:0]     out_store_data_o,
    output logic [4:0]      out_rd_o,
    output logic            out_illegal_o
);

    op_class_t   dec_class;
    logic [2:0]  dec_funct;
    logic        dec_alt;
    logic [31:0] dec_imm;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        dec_rs1_used;
    logic        dec_rs2_used;
    logic        dec_illegal;

    decode_core #(
        .NREGS(NREGS)
    ) u_decode_core (
        .inst_i     (in_inst_i),
        .op_class_o (dec_class),
        .funct_o    (dec_funct),
        .alt_o      (dec_alt),
        .imm_o      (dec_imm),
        .rs1_o      (dec_rs1),
        .rs2_o      (dec_rs2),
        .rd_o       (dec_rd),
        .rs1_used_o (dec_rs1_used),
        .rs2_used_o (dec_rs2_used),
        .illegal_o  (dec_illegal)
    );

    dec_out_t        out_d, out_q;
    logic [PC_W-1:0] pc_d, pc_q;
    logic            out_valid_d, out_valid_q;
    logic [31:0]     pend_d, pend_q;
    logic [31:0]     set_vec;
    logic [31:0]     clr_vec;
    logic            hazard;
    logic            accept;
    logic            out_fire;

    assign rf_raddr1_o = dec_rs1;
    assign rf_raddr2_o = dec_rs2;

    always_comb begin
        hazard = 1'b0;
        if (EN_SCOREBOARD != 0 && in_valid_i) begin
            hazard = (dec_rs1_used && pend_q[dec_rs1]) || (dec_rs2_used && pend_q[dec_rs2]);
        end
    end

    // Flush forces ready so fetch can drop its instruction in the same cycle.
    assign in_ready_o = flush_i | ((~out_valid_q | out_ready_i) & ~hazard);
    assign accept     = in_valid_i & in_ready_o & ~flush_i;
    assign out_fire   = out_valid_q & out_ready_i;

    always_comb begin
        out_d = out_q;
        pc_d  = pc_q;
        if (accept) begin
            pc_d                = in_pc_i;
            out_d.op_class      = dec_class;
            out_d.funct         = dec_funct;
            out_d.alt           = dec_alt;
            out_d.imm           = dec_imm;
            out_d.store_data    = rf_rdata2_i;
            out_d.rd            = dec_rd;
            out_d.illegal       = dec_illegal;
            case (dec_class)
                ClsAuipc, ClsJal: out_d.op_a = 32'(in_pc_i);
                ClsLui:           out_d.op_a = '0;
                default:          out_d.op_a = rf_rdata1_i;
            endcase
            case (dec_class)
                ClsCalc, ClsBranch: out_d.op_b = rf_rdata2_i;
                default:            out_d.op_b = dec_imm;
            endcase
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // A load leaving in the same cycle its register writes back keeps the bit set.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (out_fire && out_q.op_class == ClsLoad && out_q.rd != 5'd0) begin
            set_vec[out_q.rd] = 1'b1;
        end
        if (wb_valid_i) begin
            clr_vec[wb_rd_i] = 1'b1;
        end
        pend_d    = (pend_q & ~clr_vec) | set_vec;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            pc_q        <= '0;
            pend_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
        end
    end

    assign out_valid_o      = out_valid_q;
    assign out_pc_o         = pc_q;
    assign out_class_o      = out_q.op_class;
    assign out_funct_o      = out_q.funct;
    assign out_alt_o        = out_q.alt;
    assign out_op_a_o       = out_q.op_a;
    assign out_op_b_o       = out_q.op_b;
    assign out_imm_o        = out_q.imm;
    assign out_store_data_o = out_q.store_data;
    assign out_rd_o         = out_q.rd;
    assign out_illegal_o    = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus random traffic against a behavioural model.
module tb_decode_stage;
    import nyakuo_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        flush_i, in_valid_i, out_ready_i, wb_valid_i;
    logic [31:0] in_inst_i, in_pc_i, rf_rdata1_i, rf_rdata2_i;
    logic [4:0]  wb_rd_i;

    logic        in_ready_o, out_valid_o, out_alt_o, out_illegal_o;
    logic [4:0]  rf_raddr1_o, rf_raddr2_o, out_rd_o;
    logic [31:0] out_pc_o, out_op_a_o, out_op_b_o, out_imm_o, out_store_data_o;
    logic [2:0]  out_funct_o;
    op_class_t   out_class_o;

    logic        e_in_ready, e_out_valid, e_alt, e_illegal;
    logic [4:0]  e_raddr1, e_raddr2, e_rd;
    logic [31:0] e_pc, e_op_a, e_op_b, e_imm, e_sdata;
    logic [2:0]  e_funct;
    op_class_t   e_class;

    always #5 clk = ~clk;

    decode_stage #(.NREGS(32), .PC_W(32), .EN_SCOREBOARD(1)) u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .in_inst_i(in_inst_i), .in_pc_i(in_pc_i),
        .rf_raddr1_o(rf_raddr1_o), .rf_raddr2_o(rf_raddr2_o), .rf_rdata1_i(rf_rdata1_i),
        .rf_rdata2_i(rf_rdata2_i), .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_pc_o(out_pc_o),
        .out_class_o(out_class_o), .out_funct_o(out_funct_o), .out_alt_o(out_alt_o),
        .out_op_a_o(out_op_a_o), .out_op_b_o(out_op_b_o), .out_imm_o(out_imm_o),
        .out_store_data_o(out_store_data_o), .out_rd_o(out_rd_o), .out_illegal_o(out_illegal_o)
    );

    decode_stage #(.NREGS(16), .PC_W(32), .EN_SCOREBOARD(1)) u_dut_e (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .in_valid_i(in_valid_i),
        .in_ready_o(e_in_ready), .in_inst_i(in_inst_i), .in_pc_i(in_pc_i),
        .rf_raddr1_o(e_raddr1), .rf_raddr2_o(e_raddr2), .rf_rdata1_i(rf_rdata1_i),
        .rf_rdata2_i(rf_rdata2_i), .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
        .out_valid_o(e_out_valid), .out_ready_i(out_ready_i), .out_pc_o(e_pc),
        .out_class_o(e_class), .out_funct_o(e_funct), .out_alt_o(e_alt),
        .out_op_a_o(e_op_a), .out_op_b_o(e_op_b), .out_imm_o(e_imm),
        .out_store_data_o(e_sdata), .out_rd_o(e_rd), .out_illegal_o(e_illegal)
    );

    logic [31:0] rf [32];
    always_comb rf_rdata1_i = (in_inst_i[19:15] == 5'd0) ? 32'd0 : rf[in_inst_i[19:15]];
    always_comb rf_rdata2_i = (in_inst_i[24:20] == 5'd0) ? 32'd0 : rf[in_inst_i[24:20]];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state.
    typedef struct packed {
        op_class_t   cls;
        logic [2:0]  funct;
        logic        alt;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        ill;
        logic        u1;
        logic        u2;
        logic [31:0] pc;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] sdata;
    } mdec_t;

    mdec_t m_out;
    logic  m_valid;
    logic  pend [32];
    logic  obs_ready;

    function automatic mdec_t ref_decode(input logic [31:0] i);
        mdec_t      d;
        logic       has_rd;
        logic [7:0] br_ok, ld_ok, st_ok;
        logic [2:0] f3;
        logic [6:0] f7;
        br_ok  = 8'b1111_0011;
        ld_ok  = 8'b0011_0111;
        st_ok  = 8'b0000_0111;
        f3     = i[14:12];
        f7     = i[31:25];
        d      = '0;
        has_rd = 1'b0;
        d.funct = f3;
        case (i[6:0])
            7'h37: begin d.cls = ClsLui;   has_rd = 1; d.imm = {i[31:12], 12'h000}; end
            7'h17: begin d.cls = ClsAuipc; has_rd = 1; d.imm = {i[31:12], 12'h000}; end
            7'h6F: begin
                d.cls = ClsJal; has_rd = 1;
                d.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            end
            7'h67: if (f3 == 0) begin
                d.cls = ClsJalr; has_rd = 1; d.u1 = 1; d.imm = 32'($signed(i[31:20]));
            end
            7'h63: if (br_ok[f3]) begin
                d.cls = ClsBranch; d.u1 = 1; d.u2 = 1;
                d.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            end
            7'h03: if (ld_ok[f3]) begin
                d.cls = ClsLoad; has_rd = 1; d.u1 = 1; d.imm = 32'($signed(i[31:20]));
            end
            7'h23: if (st_ok[f3]) begin
                d.cls = ClsStore; d.u1 = 1; d.u2 = 1;
                d.imm = 32'($signed({i[31:25], i[11:7]}));
            end
            7'h13: if ((f3 != 1 && f3 != 5) || f7 == 0 || (f3 == 5 && f7 == 7'h20)) begin
                d.cls = ClsCalcImm; has_rd = 1; d.u1 = 1; d.imm = 32'($signed(i[31:20]));
                d.alt = (f3 == 5) ? i[30] : 1'b0;
            end
            7'h33: if (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) begin
                d.cls = ClsCalc; has_rd = 1; d.u1 = 1; d.u2 = 1; d.alt = i[30];
            end
            default: d.cls = ClsIllegal;
        endcase
        d.ill = (d.cls == ClsIllegal);
        if (d.ill) begin
            d.u1 = 0; d.u2 = 0; has_rd = 0;
        end
        d.rd = has_rd ? i[11:7] : 5'd0;
        return d;
    endfunction

    function automatic logic [31:0] rf_val(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : rf[a];
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_out   = '0;
        for (int k = 0; k < 32; k++) pend[k] = 1'b0;
    endtask

    // One clock: drive inputs, compare at the falling edge, advance the model, pass the edge.
    task automatic step(input logic [31:0] inst, input logic [31:0] pc, input logic v,
                        input logic rdy, input logic fl, input logic wbv, input logic [4:0] wbr);
        mdec_t d;
        logic  haz, rdy_m, hs, acc;
        in_inst_i = inst; in_pc_i = pc; in_valid_i = v; out_ready_i = rdy;
        flush_i = fl; wb_valid_i = wbv; wb_rd_i = wbr;
        #4;
        d     = ref_decode(inst);
        haz   = v && ((d.u1 && pend[inst[19:15]]) || (d.u2 && pend[inst[24:20]]));
        rdy_m = fl || ((!m_valid || rdy) && !haz);
        check_val("in_ready", 32'(in_ready_o), 32'(rdy_m));
        check_val("raddr1", 32'(rf_raddr1_o), 32'(inst[19:15]));
        check_val("raddr2", 32'(rf_raddr2_o), 32'(inst[24:20]));
        check_val("out_valid", 32'(out_valid_o), 32'(m_valid));
        if (m_valid) begin
            check_val("out_pc", out_pc_o, m_out.pc);
            check_val("out_class", 32'(out_class_o), 32'(m_out.cls));
            check_val("out_illegal", 32'(out_illegal_o), 32'(m_out.ill));
            check_val("out_rd", 32'(out_rd_o), 32'(m_out.rd));
            if (!m_out.ill) begin
                check_val("out_alt", 32'(out_alt_o), 32'(m_out.alt));
                check_val("out_imm", out_imm_o, m_out.imm);
                check_val("out_op_a", out_op_a_o, m_out.op_a);
                check_val("out_op_b", out_op_b_o, m_out.op_b);
                check_val("out_store_data", out_store_data_o, m_out.sdata);
                if (m_out.cls != ClsLui && m_out.cls != ClsAuipc && m_out.cls != ClsJal)
                    check_val("out_funct", 32'(out_funct_o), 32'(m_out.funct));
            end
        end
        obs_ready = in_ready_o;
        hs  = m_valid && rdy;
        acc = v && rdy_m && !fl;
        if (wbv) pend[wbr] = 1'b0;
        if (hs && m_out.cls == ClsLoad && m_out.rd != 0) pend[m_out.rd] = 1'b1;
        if (acc) begin
            m_out       = d;
            m_out.pc    = pc;
            m_out.sdata = rf_val(inst[24:20]);
            m_out.op_a  = (d.cls == ClsAuipc || d.cls == ClsJal) ? pc :
                          (d.cls == ClsLui) ? 32'd0 : rf_val(inst[19:15]);
            m_out.op_b  = (d.cls == ClsCalc || d.cls == ClsBranch) ? rf_val(inst[24:20]) : d.imm;
        end
        if (fl) m_valid = 1'b0;
        else if (acc) m_valid = 1'b1;
        else if (hs) m_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] op, f7;
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = 3'($urandom);
        case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        case ($urandom_range(0, 12))
            0:       op = 7'h37;
            1:       op = 7'h17;
            2:       op = 7'h6F;
            3:       op = 7'h67;
            4:       op = 7'h63;
            5, 6:    op = 7'h03;
            7:       op = 7'h23;
            8:       op = 7'h13;
            9:       op = 7'h33;
            10:      op = 7'h0F;
            11:      op = 7'h73;
            default: return $urandom;
        endcase
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    localparam logic [31:0] IAddi  = 32'h0051_0093;
    localparam logic [31:0] IAddi2 = 32'h0070_0113;
    localparam logic [31:0] ILw    = 32'h0002_2183;
    localparam logic [31:0] IAdd   = 32'h0011_82B3;
    localparam logic [31:0] ILui   = 32'h1234_53B7;
    localparam logic [31:0] IAuipc = 32'h0000_1297;
    localparam logic [31:0] IAdd16 = 32'h0020_8833;

    initial begin
        for (int k = 0; k < 32; k++) rf[k] = $urandom;
        rf[0] = 32'd0;
        rf[2] = 32'd10;
        rst_ni = 1'b0;
        flush_i = 0; in_valid_i = 0; out_ready_i = 0; wb_valid_i = 0;
        wb_rd_i = 0; in_inst_i = 0; in_pc_i = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_val("rst_out_valid", 32'(out_valid_o), 32'd0);
        check_val("rst_in_ready", 32'(in_ready_o), 32'd1);
        check_val("rst_class", 32'(out_class_o), 32'd0);
        check_val("rst_pc", out_pc_o, 32'd0);
        check_val("rst_op_a", out_op_a_o, 32'd0);
        check_val("rst_op_b", out_op_b_o, 32'd0);
        check_val("rst_imm", out_imm_o, 32'd0);
        check_val("rst_rd", 32'(out_rd_o), 32'd0);
        check_val("rst_illegal", 32'(out_illegal_o), 32'd0);
        #4 rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // ADDI x1,x2,5 with x2 = 10.
        step(IAddi, 32'h40, 1, 1, 0, 0, 0);
        check_val("addi_class", 32'(out_class_o), 32'(ClsCalcImm));
        check_val("addi_op_a", out_op_a_o, 32'd10);
        check_val("addi_op_b", out_op_b_o, 32'd5);
        check_val("addi_rd", 32'(out_rd_o), 32'd1);
        check_val("addi_funct", 32'(out_funct_o), 32'd0);

        step(ILui, 32'h44, 1, 1, 0, 0, 0);
        check_val("lui_op_a", out_op_a_o, 32'd0);
        check_val("lui_op_b", out_op_b_o, 32'h1234_5000);
        step(IAuipc, 32'h100, 1, 1, 0, 0, 0);
        check_val("auipc_op_a", out_op_a_o, 32'h100);
        check_val("auipc_op_b", out_op_b_o, 32'h1000);

        // Load-use: LW x3 leaves, ADD x5,x3,x1 waits for the write-back of x3.
        step(ILw, 32'h104, 1, 1, 0, 0, 0);
        step(32'h0, 32'h0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(IAdd, 32'h108, 1, 1, 0, 0, 0);
            check_val("lu_stall", 32'(obs_ready), 32'd0);
        end
        step(IAdd, 32'h108, 1, 1, 0, 1, 5'd3);
        check_val("lu_wb_cycle", 32'(obs_ready), 32'd0);
        step(IAdd, 32'h108, 1, 1, 0, 0, 0);
        check_val("lu_accept", 32'(obs_ready), 32'd1);
        check_val("lu_add_rd", 32'(out_rd_o), 32'd5);

        // Back-pressure holds the output.
        step(IAddi, 32'h10C, 1, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(IAddi2, 32'h110, 1, 0, 0, 0, 0);
            check_val("bp_ready", 32'(obs_ready), 32'd0);
            check_val("bp_rd_hold", 32'(out_rd_o), 32'd1);
            check_val("bp_op_b_hold", out_op_b_o, 32'd5);
        end
        step(IAddi2, 32'h110, 1, 1, 0, 0, 0);
        check_val("bp_release", 32'(obs_ready), 32'd1);
        check_val("bp_next_rd", 32'(out_rd_o), 32'd2);

        // Flush during a hazard stall.
        step(ILw, 32'h114, 1, 1, 0, 0, 0);
        step(32'h0, 32'h0, 0, 1, 0, 0, 0);
        step(IAddi, 32'h118, 1, 0, 0, 0, 0);
        step(IAdd, 32'h11C, 1, 0, 0, 0, 0);
        check_val("fl_stall", 32'(obs_ready), 32'd0);
        step(IAdd, 32'h11C, 1, 0, 1, 0, 0);
        check_val("fl_out_valid", 32'(out_valid_o), 32'd0);
        step(32'h0, 32'h0, 0, 0, 0, 0, 0);
        step(IAdd, 32'h11C, 1, 1, 0, 0, 0);
        check_val("fl_pend_kept", 32'(obs_ready), 32'd0);

        // Reset in the middle of a stall.
        step(IAddi, 32'h120, 1, 0, 0, 0, 0);
        step(IAdd, 32'h124, 1, 0, 0, 0, 0);
        in_inst_i = IAdd; in_valid_i = 1; out_ready_i = 0;
        rst_ni = 1'b0;
        #2;
        check_val("mid_rst_valid", 32'(out_valid_o), 32'd0);
        check_val("mid_rst_ready", 32'(in_ready_o), 32'd1);
        model_reset();
        in_valid_i = 0;
        #2 rst_ni = 1'b1;
        @(posedge clk);
        #1;
        step(IAdd, 32'h200, 1, 1, 0, 0, 0);
        check_val("post_rst_accept", 32'(obs_ready), 32'd1);
        check_val("post_rst_rd", 32'(out_rd_o), 32'd5);

        // RV32E instance sees x16 as illegal.
        step(IAdd16, 32'h204, 1, 1, 0, 0, 0);
        check_val("e_valid", 32'(e_out_valid), 32'd1);
        check_val("e_illegal", 32'(e_illegal), 32'd1);
        check_val("e_class", 32'(e_class), 32'(ClsIllegal));
        check_val("e_rd", 32'(e_rd), 32'd0);
        check_val("i_add16_rd", 32'(out_rd_o), 32'd16);
        step(IAdd, 32'h208, 1, 1, 0, 0, 0);
        check_val("e_legal_add", 32'(e_illegal), 32'd0);
        check_val("e_legal_rd", 32'(e_rd), 32'd5);
        step(32'h0, 32'h0, 0, 1, 0, 0, 0);

        // Random traffic.
        for (int k = 1; k < 32; k++) rf[k] = $urandom;
        for (int n = 0; n < 3000; n++) begin
            step(rand_inst(), $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
